turn_scheduler: RTL

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/turn_scheduler_if.sv | 27 ++
 rtl/turn_scheduler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/turn_scheduler_if.sv
// turn_scheduler_if -- handshake bundle between the game controller and the
// turn scheduler.
//   master : drives n_players, start, guess_valid, guess_hit, win;
//            observes cur_player, move_en, turn_over, game_over, streak
//   slave  : the scheduler itself (mirror directions)
interface turn_scheduler_if;
  logic [3:0] n_players;   // player count, valid 2..4
  logic       start;       // one-cycle pulse, begin a game
  logic       guess_valid; // one-cycle pulse, current player guessed
  logic       guess_hit;   // guess matched, qualified by guess_valid
  logic       win;         // level, some player reached the goal
  logic [1:0] cur_player;  // player holding the turn
  logic [3:0] move_en;     // one-hot advance enable for position counters
  logic       turn_over;   // one-cycle pulse on turn handover
  logic       game_over;   // level, game finished
  logic [4:0] streak;      // consecutive hits in the current turn

  modport master (
    output n_players, start, guess_valid, guess_hit, win,
    input  cur_player, move_en, turn_over, game_over, streak
  );

  modport slave (
    input  n_players, start, guess_valid, guess_hit, win,
    output cur_player, move_en, turn_over, game_over, streak
  );
endinterface

// File: rtl/turn_scheduler.sv
// turn_scheduler -- sequences turns of a 2..4 player tile-guessing game.
// A hit grants the current player a one-cycle move_en pulse and keeps the
// turn; a miss hands the turn to the next player. win ends the game.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : turn_scheduler_if.slave (inputs n_players/start/guess_valid/
//         guess_hit/win, outputs cur_player/move_en/turn_over/game_over/streak)
//
// Parameters:
//   TIMEOUT_CYC : idle cycles in WAIT_GUESS before a forced pass
//   STREAK_MAX  : saturation value of the streak counter
//
// Optional feature: define TURN_TIMEOUT_EN to enable the idle-turn timeout.
// Without it WAIT_GUESS waits for a guess indefinitely.
module turn_scheduler #(
  parameter int TIMEOUT_CYC = 255,
  parameter int STREAK_MAX  = 23
) (
  input  logic              clk,
  input  logic              rst,
  turn_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, WAIT_GUESS, MOVE, PASS, DONE} state_t;

  state_t     state_reg, state_next;
  logic [1:0] cur_player_reg, cur_player_next;
  logic [4:0] streak_reg, streak_next;
  logic [3:0] n_lat_reg, n_lat_next;
  logic       n_valid;
  logic       last_player;
  logic       timeout;

  if (TIMEOUT_CYC < 1 || STREAK_MAX < 0 || STREAK_MAX > 31) begin : g_bad_param
    $error("turn_scheduler: TIMEOUT_CYC must be >= 1 and STREAK_MAX 0..31");
  end

  assign n_valid     = (bus.n_players >= 4'd2) && (bus.n_players <= 4'd4);
  assign last_player = ({2'b00, cur_player_reg} == (n_lat_reg - 4'd1));

`ifdef TURN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  // Counts cycles spent waiting; value k during the (k+1)-th waiting cycle,
  // so the pass fires after exactly TIMEOUT_CYC idle cycles.
  assign timeout = (wait_cnt_reg == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    wait_cnt_next = '0;
    if (state_reg == WAIT_GUESS && state_next == WAIT_GUESS && !bus.guess_valid)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_reg <= '0;
    else     wait_cnt_reg <= wait_cnt_next;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cur_player_reg <= 2'd0;
      streak_reg     <= 5'd0;
      n_lat_reg      <= 4'd0;
    end else begin
      state_reg      <= state_next;
      cur_player_reg <= cur_player_next;
      streak_reg     <= streak_next;
      n_lat_reg      <= n_lat_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_player_next = cur_player_reg;
    streak_next     = streak_reg;
    n_lat_next      = n_lat_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start && n_valid) begin
          state_next      = WAIT_GUESS;
          n_lat_next      = bus.n_players;
          cur_player_next = 2'd0;
          streak_next     = 5'd0;
        end
      end
      WAIT_GUESS: begin
        // win outranks a simultaneous guess: no move is granted
        if (bus.win)              state_next = DONE;
        else if (bus.guess_valid) state_next = bus.guess_hit ? MOVE : PASS;
        else if (timeout)         state_next = PASS;
      end
      MOVE: begin
        // the move pulse and its streak credit complete even if win arrives
        if (streak_reg < 5'(STREAK_MAX)) streak_next = streak_reg + 5'd1;
        state_next = bus.win ? DONE : WAIT_GUESS;
      end
      PASS: begin
        streak_next     = 5'd0;
        cur_player_next = last_player ? 2'd0 : cur_player_reg + 2'd1;
        state_next      = bus.win ? DONE : WAIT_GUESS;
      end
      DONE: begin
        if (bus.start) begin
          cur_player_next = 2'd0;
          streak_next     = 5'd0;
          if (n_valid) begin
            state_next = WAIT_GUESS;
            n_lat_next = bus.n_players;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so an asynchronous reset
  // removes them at once, truncating any move pulse.
  for (genvar gi = 0; gi < 4; gi++) begin : g_move_en
    assign bus.move_en[gi] = (state_reg == MOVE) && (cur_player_reg == 2'(gi));
  end

  assign bus.cur_player = cur_player_reg;
  assign bus.turn_over  = (state_reg == PASS);
  assign bus.game_over  = (state_reg == DONE);
  assign bus.streak     = streak_reg;

endmodule
